// File: rtl/i2c_req_arbiter_if.sv
// Bundle of requester-side and master-side signals around the I2C request arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives requests and busy.
interface i2c_req_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   i_req;
  logic [7*N_REQ-1:0] i_addr;
  logic [8*N_REQ-1:0] i_data;
  logic [N_REQ-1:0]   i_rnw;
  logic [3*N_REQ-1:0] i_word_cnt;
  logic [N_REQ-1:0]   o_gnt;
  logic [N_REQ-1:0]   o_done;
  logic [N_REQ-1:0]   o_err;
  logic               o_m_start;
  logic [6:0]         o_m_addr;
  logic [7:0]         o_m_data;
  logic               o_m_rnw;
  logic [2:0]         o_m_word_cnt;
  logic               i_m_busy;

  modport master (
    output i_req, i_addr, i_data, i_rnw, i_word_cnt, i_m_busy,
    input  o_gnt, o_done, o_err, o_m_start, o_m_addr, o_m_data, o_m_rnw, o_m_word_cnt
  );

  modport slave (
    input  i_req, i_addr, i_data, i_rnw, i_word_cnt, i_m_busy,
    output o_gnt, o_done, o_err, o_m_start, o_m_addr, o_m_data, o_m_rnw, o_m_word_cnt
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ command sources.
// Latches the winner's command, pulses start, follows busy to completion and pulses done/err.
module i2c_req_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  i2c_req_arbiter_if.slave     bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic             start_q, start_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             rnw_q, rnw_d;
  logic [2:0]       wcnt_q, wcnt_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [PW-1:0]      offset;
  logic [PW:0]        sum;
  logic [PW-1:0]      winner;
  logic               any_req;

  // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit is the winner's offset.
  always_comb begin
    req_dbl = {bus.i_req, bus.i_req} >> rr_ptr_q;
    req_rot = req_dbl[N_REQ-1:0];
    any_req = |bus.i_req;
    offset  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) offset = PW'(j);
    end
    sum    = {1'b0, rr_ptr_q} + {1'b0, offset};
    winner = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : PW'(sum);
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    start_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    rnw_d    = rnw_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d    = N_REQ'(1) << winner;
          start_d  = 1'b1;
          rr_ptr_d = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
          for (int k = 0; k < N_REQ; k++) begin
            if (winner == PW'(k)) begin
              addr_d = bus.i_addr[7*k +: 7];
              data_d = bus.i_data[8*k +: 8];
              rnw_d  = bus.i_rnw[k];
              wcnt_d = bus.i_word_cnt[3*k +: 3];
            end
          end
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.i_m_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // Master never acknowledged the start: finish the slot with an error.
          done_d  = gnt_q;
          err_d   = gnt_q;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.i_m_busy) begin
          done_d  = gnt_q;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rnw_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rnw_q    <= rnw_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign bus.o_gnt        = gnt_q;
  assign bus.o_done       = done_q;
  assign bus.o_err        = err_q;
  assign bus.o_m_start    = start_q;
  assign bus.o_m_addr     = addr_q;
  assign bus.o_m_data     = data_q;
  assign bus.o_m_rnw      = rnw_q;
  assign bus.o_m_word_cnt = wcnt_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: expected grants are predicted from a round-robin
// model and queued when requests are driven, then popped when the start pulse appears.
module tb_i2c_req_arbiter;
  localparam int N_REQ        = 4;
  localparam int BUSY_TIMEOUT = 16;

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic [7:0] data;
    logic       rnw;
    logic [2:0] cnt;
  } txn_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   exp_ptr = 0;
  txn_t exp_q[$];

  i2c_req_arbiter_if #(.N_REQ(N_REQ)) bus();

  i2c_req_arbiter #(.N_REQ(N_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N_REQ-1:0] req, input int ptr);
    for (int i = 0; i < N_REQ; i++) begin
      if (req[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
    end
    return -1;
  endfunction

  task automatic set_fields(input int k, input logic [6:0] a, input logic [7:0] d,
                            input logic r, input logic [2:0] w);
    bus.i_addr[7*k +: 7]     = a;
    bus.i_data[8*k +: 8]     = d;
    bus.i_rnw[k]             = r;
    bus.i_word_cnt[3*k +: 3] = w;
  endtask

  // Predict the next grant from the bench's own pointer and queue the expected command.
  task automatic push_expected();
    txn_t t;
    t.idx  = pick(bus.i_req, exp_ptr);
    if (t.idx < 0) t.idx = 0;
    t.addr = bus.i_addr[7*t.idx +: 7];
    t.data = bus.i_data[8*t.idx +: 8];
    t.rnw  = bus.i_rnw[t.idx];
    t.cnt  = bus.i_word_cnt[3*t.idx +: 3];
    exp_q.push_back(t);
    exp_ptr = (t.idx + 1) % N_REQ;
  endtask

  task automatic await_start(output int n);
    n = -1;
    for (int c = 1; c <= 60 && n < 0; c++) begin
      @(negedge clk);
      if (bus.o_m_start === 1'b1) n = c;
    end
  endtask

  task automatic await_done(output int n);
    n = -1;
    for (int c = 1; c <= 100 && n < 0; c++) begin
      @(negedge clk);
      if (bus.o_done !== '0) n = c;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    bus.i_req = '0; bus.i_addr = '0; bus.i_data = '0;
    bus.i_rnw = '0; bus.i_word_cnt = '0; bus.i_m_busy = 1'b0;
    repeat (2) @(negedge clk);
    exp_ptr = 0;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.i_req = '1; bus.i_m_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_gnt, bus.o_done, bus.o_err, bus.o_m_start, bus.o_m_addr, bus.o_m_data,
         bus.o_m_rnw, bus.o_m_word_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: gnt=%b done=%b err=%b start=%b addr=%h data=%h, required all 0",
               bus.o_gnt, bus.o_done, bus.o_err, bus.o_m_start, bus.o_m_addr, bus.o_m_data);
    end
    do_reset();
  endtask

  task automatic test_single();
    int n;
    txn_t t;
    logic [N_REQ-1:0] g;
    set_fields(1, 7'h50, 8'hA5, 1'b0, 3'd1);
    bus.i_req = 4'b0010;
    push_expected();
    await_start(n);
    t = exp_q.pop_front();
    g = N_REQ'(1) << t.idx;
    checks++;
    if (n !== 1) begin
      errors++; $display("[TB] FAIL single_start_latency: got %0d cycles, required 1", n);
    end
    checks++;
    if ({bus.o_gnt, bus.o_m_addr, bus.o_m_data, bus.o_m_rnw, bus.o_m_word_cnt} !==
        {g, t.addr, t.data, t.rnw, t.cnt} || g !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL single_launch: gnt=%b addr=%h data=%h, required gnt=0010 addr=50 data=a5",
               bus.o_gnt, bus.o_m_addr, bus.o_m_data);
    end
    bus.i_m_busy = 1'b1;
    repeat (20) @(negedge clk);
    bus.i_m_busy = 1'b0;
    await_done(n);
    checks++;
    if (n !== 1 || bus.o_done !== 4'b0010 || bus.o_err !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_done: after %0d cycles done=%b err=%b, required 1 cycle done=0010 err=0000",
               n, bus.o_done, bus.o_err);
    end
    bus.i_req = '0;
    @(negedge clk);
    checks++;
    if (bus.o_done !== '0 || bus.o_gnt !== '0) begin
      errors++;
      $display("[TB] FAIL single_release: done=%b gnt=%b, required 0000 0000", bus.o_done, bus.o_gnt);
    end
  endtask

  task automatic test_round_robin();
    int n;
    txn_t t;
    logic [N_REQ-1:0] g;
    nrst = 1'b0;
    for (int k = 0; k < N_REQ; k++) set_fields(k, 7'(8'h20 + k), 8'(8'hC0 + k), k[0], 3'(k + 1));
    bus.i_req = 4'b1111;
    bus.i_m_busy = 1'b0;
    repeat (2) @(negedge clk);
    exp_ptr = 0;
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_expected();
      await_start(n);
      t = exp_q.pop_front();
      g = N_REQ'(1) << t.idx;
      checks++;
      if (n < 0 || {bus.o_gnt, bus.o_m_addr, bus.o_m_data, bus.o_m_rnw, bus.o_m_word_cnt} !==
                   {g, t.addr, t.data, t.rnw, t.cnt}) begin
        errors++;
        $display("[TB] FAIL rr_grant[%0d]: wait=%0d gnt=%b addr=%h, required gnt=%b addr=%h",
                 i, n, bus.o_gnt, bus.o_m_addr, g, t.addr);
      end
      bus.i_m_busy = 1'b1;
      repeat (3) @(negedge clk);
      bus.i_m_busy = 1'b0;
      await_done(n);
      if (i == 4) bus.i_req = '0;
      checks++;
      if (n !== 1 || bus.o_done !== g || bus.o_m_start !== 1'b0 || bus.o_err !== '0) begin
        errors++;
        $display("[TB] FAIL rr_done[%0d]: wait=%0d done=%b start=%b err=%b, required done=%b",
                 i, n, bus.o_done, bus.o_m_start, bus.o_err, g);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int n;
    txn_t t;
    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] order [3];
    order[0] = 4'b0100; order[1] = 4'b0001; order[2] = 4'b0100;
    bus.i_req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      push_expected();
      await_start(n);
      t = exp_q.pop_front();
      g = N_REQ'(1) << t.idx;
      checks++;
      if (n < 0 || bus.o_gnt !== g || g !== order[i] || bus.o_m_addr !== t.addr) begin
        errors++;
        $display("[TB] FAIL fair_grant[%0d]: wait=%0d gnt=%b addr=%h, required gnt=%b addr=%h",
                 i, n, bus.o_gnt, bus.o_m_addr, order[i], t.addr);
      end
      bus.i_m_busy = 1'b1;
      repeat (2) @(negedge clk);
      bus.i_m_busy = 1'b0;
      await_done(n);
      if (i == 2) bus.i_req = '0;
      checks++;
      if (n !== 1 || bus.o_done !== g) begin
        errors++;
        $display("[TB] FAIL fair_done[%0d]: wait=%0d done=%b, required done=%b", i, n, bus.o_done, g);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    txn_t t;
    logic [N_REQ-1:0] g;
    bus.i_req = 4'b1000;
    bus.i_m_busy = 1'b0;
    push_expected();
    await_start(n);
    t = exp_q.pop_front();
    g = N_REQ'(1) << t.idx;
    checks++;
    if (n < 0 || bus.o_gnt !== g) begin
      errors++; $display("[TB] FAIL timeout_grant: wait=%0d gnt=%b, required %b", n, bus.o_gnt, g);
    end
    await_done(n);
    bus.i_req = '0;
    checks++;
    if (n !== BUSY_TIMEOUT + 1 || bus.o_done !== g || bus.o_err !== g) begin
      errors++;
      $display("[TB] FAIL timeout_done: after %0d cycles done=%b err=%b, required %0d cycles done=err=%b",
               n, bus.o_done, bus.o_err, BUSY_TIMEOUT + 1, g);
    end
    @(negedge clk);
    checks++;
    if (bus.o_err !== '0 || bus.o_done !== '0) begin
      errors++; $display("[TB] FAIL timeout_pulse_width: err=%b done=%b, required 0000", bus.o_err, bus.o_done);
    end
  endtask

  task automatic test_field_change();
    int n;
    txn_t t;
    set_fields(0, 7'h3C, 8'h5A, 1'b1, 3'd4);
    bus.i_req = 4'b0001;
    push_expected();
    await_start(n);
    t = exp_q.pop_front();
    bus.i_m_busy = 1'b1;
    repeat (3) @(negedge clk);
    set_fields(0, 7'h11, 8'hFF, 1'b0, 3'd7);
    bus.i_req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (n < 0 || bus.o_m_addr !== 7'h3C || bus.o_m_data !== t.data || bus.o_m_rnw !== t.rnw ||
        bus.o_m_word_cnt !== t.cnt || bus.o_gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL field_hold: addr=%h data=%h gnt=%b, required addr=3c data=%h gnt=0001",
               bus.o_m_addr, bus.o_m_data, bus.o_gnt, t.data);
    end
    bus.i_m_busy = 1'b0;
    await_done(n);
    checks++;
    if (n !== 1 || bus.o_done !== 4'b0001) begin
      errors++; $display("[TB] FAIL drop_done: wait=%0d done=%b, required 1 and 0001", n, bus.o_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    txn_t t;
    set_fields(2, 7'h44, 8'h12, 1'b0, 3'd2);
    bus.i_req = 4'b0100;
    push_expected();
    await_start(n);
    t = exp_q.pop_front();
    bus.i_m_busy = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (n < 0 || bus.o_gnt !== (N_REQ'(1) << t.idx)) begin
      errors++; $display("[TB] FAIL midreset_pre: gnt=%b, required 0100", bus.o_gnt);
    end
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({bus.o_gnt, bus.o_done, bus.o_err, bus.o_m_start, bus.o_m_addr, bus.o_m_data,
         bus.o_m_rnw, bus.o_m_word_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_async: gnt=%b addr=%h data=%h, required all 0",
               bus.o_gnt, bus.o_m_addr, bus.o_m_data);
    end
    bus.i_m_busy = 1'b0;
    set_fields(1, 7'h61, 8'h99, 1'b1, 3'd3);
    set_fields(3, 7'h73, 8'h77, 1'b0, 3'd5);
    bus.i_req = 4'b1010;
    repeat (2) @(negedge clk);
    exp_ptr = 0;
    nrst = 1'b1;
    push_expected();
    await_start(n);
    t = exp_q.pop_front();
    checks++;
    if (n !== 1 || bus.o_gnt !== 4'b0010 || bus.o_m_addr !== t.addr || t.idx != 1) begin
      errors++;
      $display("[TB] FAIL midreset_first_grant: wait=%0d gnt=%b addr=%h, required gnt=0010 addr=61",
               n, bus.o_gnt, bus.o_m_addr);
    end
    bus.i_m_busy = 1'b1;
    @(negedge clk);
    bus.i_m_busy = 1'b0;
    await_done(n);
    bus.i_req = '0;
    checks++;
    if (n < 0 || bus.o_done !== 4'b0010) begin
      errors++; $display("[TB] FAIL midreset_done: wait=%0d done=%b, required 0010", n, bus.o_done);
    end
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting i2c_req_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_field_change();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
